lpif_txrx_asym_tx_framer: RTL and testbench
===========================================

// Module: lpif_txrx_asym_tx_framer
// PURPOSE
//  Parametrised TX framer for the LPIF-over-AIB asymmetric datapath.
//  - Takes one wide logic-link word per frame over a valid/ready handshake.
//  - Serialises the word over BEATS clocks across NUM_CH PHY channels.
//  - Inserts the strobe and word-marker user bits at configurable locations.
//  - Sits between the LPIF logic link and the AIB adapter TX ports.
//  - Generalises the fixed 2-channel full-rate concat, which has tied-off packetisation.
// PARAMETERS
//  NUM_CH      2   number of PHY channels (>=1)
//  CH_W        40  bits per channel per clock
//  BEATS       2   clocks per user word (1 = full rate, 2 = half, 4 = quarter)
//  STB_LOC     1   strobe bit position inside each channel
//  MRK_LOC     39  marker bit position inside each channel
//  STB_PERIOD  0   strobe cadence in clocks; 0 = persistent strobe (always 1)
//  PL_W        CH_W-2 (derived) payload bits per channel per beat
//  DATA_W      NUM_CH*PL_W*BEATS (derived) user word width
// PORTS
//  clk_wr      in   1              TX clock
//  rst_wr_n    in   1              asynchronous active-low reset
//  tx_online   in   1              link up; framing runs only while high
//  tx_data     in   DATA_W         user word
//  tx_valid    in   1              tx_data valid
//  tx_ready    out  1              framer accepts tx_data this cycle
//  tx_frame_vld out 1              current tx_phy beat carries user data (not idle fill)
//  tx_phy      out  NUM_CH*CH_W    PHY bus; channel c occupies [c*CH_W +: CH_W]
// BEHAVIOUR
//  Reset values
//  - tx_phy=0, tx_ready=0, tx_frame_vld=0.
//  - Internal state beat_cnt=0, stb_cnt=0, hold register=0.
//  Handshake
//  - tx_ready = tx_online & (beat_cnt==0). Combinational; it does not depend on tx_valid.
//  - A word is accepted on a clock edge where tx_valid & tx_ready are both high.
//  Latency
//  - The word is accepted at edge T.
//  - Beat b of that word appears on the registered tx_phy at T+1+b.
//  - Peak throughput is one word every BEATS clocks.
//  Beat counter
//  - While tx_online is high, beat_cnt increments modulo BEATS every clock, whether or not data flows.
//  - The marker cadence is therefore persistent.
//  Idle frame
//  - When no word is accepted at beat 0, the frame is idle.
//  - Payload is all zero; strobe and marker are still driven; tx_frame_vld=0 for all beats of that frame.
//  Payload map
//  - Channel c, beat b carries tx_data[(b*NUM_CH+c)*PL_W +: PL_W].
//  - Payload bits fill channel bits 0..CH_W-1 in ascending order, skipping STB_LOC and MRK_LOC.
//  Marker
//  - Bit MRK_LOC = 1 in every channel on the last beat (beat_cnt==BEATS-1); 0 otherwise.
//  - With BEATS=1 the marker is always 1.
//  Strobe
//  - STB_PERIOD=0: bit STB_LOC is always 1.
//  - Otherwise stb_cnt counts 0..STB_PERIOD-1 while online, and the strobe is 1 in every channel when stb_cnt==0.
//  tx_online low
//  - Next edge: beat_cnt=0, stb_cnt=0, hold cleared, tx_phy=0, tx_frame_vld=0.
//  - tx_ready is 0 while tx_online is low.
//  tx_online falling mid-frame
//  - The partial frame is abandoned and not resumed.
//  - The logic link must re-send that word.
//  tx_online rising
//  - tx_ready=1 in the first online cycle; the strobe fires on the first emitted beat.
//  Parameter checks
//  - Elaboration $error if STB_LOC==MRK_LOC.
//  - Elaboration $error if either location >= CH_W.
//  - Elaboration $error if BEATS<1 or NUM_CH<1.
// STRUCTURE
//  Package lpif_asym_pkg
//  - Function payload_to_phy_bit(idx, STB_LOC, MRK_LOC) returning the channel bit position.
//  - Beat-count width helper.
//  Sub-module lpif_asym_ch_insert (combinational, one instance per channel)
//  - Merges PL_W payload, stb and mrk into CH_W bits.
//  Top level
//  - beat/strobe counters, hold register (DATA_W minus beat-0 slice), output register.
// TESTING
//  1 Reset: assert rst_wr_n=0 mid-traffic -> tx_phy=0, tx_ready=0, tx_frame_vld=0 at once, asynchronously.
//  2 NUM_CH=2, CH_W=40, BEATS=1, STB_PERIOD=0; send word with data[0]=data[1]=data[38]=1:
//    - next clock: phy0[0]=phy0[2]=phy1[0]=1.
//    - phy0[1]=phy0[39]=phy1[1]=phy1[39]=1 (strobe and marker).
//    - all other bits 0.
//  3 BEATS=2, words A,B with tx_valid held high:
//    - tx_ready toggles 1,0,1,0.
//    - tx_phy beats A0,A1,B0,B1; marker 0,1,0,1; tx_frame_vld=1 on all four beats.
//  4 BEATS=2, tx_valid=0 for 3 frames -> payload 0, marker 0,1 repeating, tx_frame_vld=0.
//  5 STB_PERIOD=4, online from cycle 0 -> strobe=1 on emitted beats 0,4,8 only, all channels equal.
//  6 BEATS=4, drop tx_online during beat 1:
//    - next clock: tx_phy=0, tx_ready=0.
//    - re-raise tx_online: tx_ready=1 the same cycle; next word starts at beat 0 with marker pattern 0,0,0,1.

Source files
------------

// File: rtl/lpif_asym_pkg.sv
// Shared helpers for the LPIF-over-AIB asymmetric TX framer: counter width
// sizing and the payload-to-channel bit map used by every channel inserter.
package lpif_asym_pkg;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Channel bit position for payload bit idx. Payload fills the channel in
   // ascending order and steps over the strobe and marker locations.
   function automatic int payload_to_phy_bit(input int idx,
                                             input int stb_loc,
                                             input int mrk_loc);
      int lo;
      int hi;
      int pos;
      lo  = (stb_loc < mrk_loc) ? stb_loc : mrk_loc;
      hi  = (stb_loc < mrk_loc) ? mrk_loc : stb_loc;
      pos = idx;
      if (pos >= lo) pos = pos + 1;
      if (pos >= hi) pos = pos + 1;
      return pos;
   endfunction

endpackage

// File: rtl/lpif_asym_ch_insert.sv
// Per-channel merge of one beat of payload with the strobe and marker user
// bits. Purely combinational; the top level registers the assembled bus.
module lpif_asym_ch_insert
   import lpif_asym_pkg::*;
#(
   parameter  int CH_W    = 40,
   parameter  int STB_LOC = 1,
   parameter  int MRK_LOC = 39,
   localparam int PL_W    = CH_W - 2
) (
   input  logic [PL_W-1:0] pl,
   input  logic            stb,
   input  logic            mrk,
   output logic [CH_W-1:0] ch
);

   // Each payload bit lands on a fixed channel bit; the two user-bit
   // locations are left free for stb and mrk, so every bit has one driver.
   for (genvar i = 0; i < PL_W; i++) begin : g_map
      localparam int POS = payload_to_phy_bit(i, STB_LOC, MRK_LOC);
      assign ch[POS] = pl[i];
   end

   assign ch[STB_LOC] = stb;
   assign ch[MRK_LOC] = mrk;

endmodule

// File: rtl/lpif_txrx_asym_tx_framer.sv
// TX framer for the LPIF-over-AIB asymmetric datapath. Accepts one wide
// logic-link word per frame and serialises it over BEATS clocks across
// NUM_CH PHY channels, inserting strobe and word-marker user bits.
module lpif_txrx_asym_tx_framer
   import lpif_asym_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int CH_W       = 40,
   parameter  int BEATS      = 2,
   parameter  int STB_LOC    = 1,
   parameter  int MRK_LOC    = 39,
   parameter  int STB_PERIOD = 0,
   localparam int PL_W       = CH_W - 2,
   localparam int DATA_W     = NUM_CH * PL_W * BEATS
) (
   input  logic                     clk_wr,
   input  logic                     rst_wr_n,
   input  logic                     tx_online,
   input  logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic                     tx_frame_vld,
   output logic [NUM_CH*CH_W-1:0]   tx_phy
);

   localparam int SLICE_W = NUM_CH * PL_W;
   localparam int BEAT_W  = cnt_w(BEATS);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

   // Parameter sanity: the user bits need distinct, in-range locations.
   if (STB_LOC == MRK_LOC) begin : g_chk_loc_eq
      $error("lpif_txrx_asym_tx_framer: STB_LOC and MRK_LOC must differ");
   end
   if (STB_LOC >= CH_W || MRK_LOC >= CH_W) begin : g_chk_loc_rng
      $error("lpif_txrx_asym_tx_framer: STB_LOC/MRK_LOC must be below CH_W");
   end
   if (BEATS < 1 || NUM_CH < 1) begin : g_chk_shape
      $error("lpif_txrx_asym_tx_framer: BEATS and NUM_CH must be at least 1");
   end

   logic [BEAT_W-1:0]        beat_cnt;
   logic                     beat_first;
   logic                     beat_last;
   logic                     accept;
   logic                     stb_now;
   logic                     frame_act;
   logic                     vld_now;
   logic [SLICE_W-1:0]       hold_slice;
   logic [SLICE_W-1:0]       beat_pl;
   logic [NUM_CH*CH_W-1:0]   phy_nxt;

   assign beat_first = (beat_cnt == '0);
   assign beat_last  = (beat_cnt == BEAT_LAST);

   // Ready only at a frame boundary while the link is up. Gating with the
   // reset input keeps ready low for the whole reset, even if online is high.
   assign tx_ready = rst_wr_n & tx_online & beat_first;
   assign accept   = tx_valid & tx_ready;

   // Free-running beat position: advances every online clock so the marker
   // cadence never depends on traffic; offline restarts it at beat 0.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         beat_cnt <= '0;
      end else if (!tx_online || beat_last) begin
         beat_cnt <= '0;
      end else begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   if (STB_PERIOD == 0) begin : g_stb_persist
      assign stb_now = 1'b1;
   end else begin : g_stb_periodic
      localparam int STB_W = cnt_w(STB_PERIOD);
      localparam logic [STB_W-1:0] STB_LAST = STB_W'(STB_PERIOD - 1);
      logic [STB_W-1:0] stb_cnt;

      // Strobe cadence counter; phase 0 on the first online clock so the
      // first emitted beat after link-up carries the strobe.
      always_ff @(posedge clk_wr or negedge rst_wr_n) begin
         if (!rst_wr_n) begin
            stb_cnt <= '0;
         end else if (!tx_online || stb_cnt == STB_LAST) begin
            stb_cnt <= '0;
         end else begin
            stb_cnt <= stb_cnt + 1'b1;
         end
      end

      assign stb_now = (stb_cnt == '0);
   end

   if (BEATS > 1) begin : g_hold
      localparam int HOLD_W = (BEATS - 1) * SLICE_W;
      logic [HOLD_W-1:0] hold_q;

      // Holds the not-yet-sent beats of the current word; shifts one beat
      // slice down per clock so the next beat is always in the low slice.
      // Idle frames and link drops load zeros, so idle payload is all zero.
      always_ff @(posedge clk_wr or negedge rst_wr_n) begin
         if (!rst_wr_n) begin
            hold_q <= '0;
         end else if (!tx_online) begin
            hold_q <= '0;
         end else if (beat_first) begin
            hold_q <= accept ? tx_data[DATA_W-1:SLICE_W] : '0;
         end else begin
            hold_q <= hold_q >> SLICE_W;
         end
      end

      assign hold_slice = hold_q[SLICE_W-1:0];
   end else begin : g_no_hold
      assign hold_slice = '0;
   end

   // Select this clock's payload slice and its frame-valid flag: beat 0 comes
   // straight from the input word, later beats from the hold register.
   // NOTE: every output of this block gets a default first so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      beat_pl = hold_slice;
      vld_now = frame_act;
      if (beat_first) begin
         beat_pl = accept ? tx_data[SLICE_W-1:0] : '0;
         vld_now = accept;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      lpif_asym_ch_insert #(
         .CH_W    (CH_W),
         .STB_LOC (STB_LOC),
         .MRK_LOC (MRK_LOC)
      ) u_ch_insert (
         .pl  (beat_pl[c*PL_W +: PL_W]),
         .stb (stb_now),
         .mrk (beat_last),
         .ch  (phy_nxt[c*CH_W +: CH_W])
      );
   end

   // Output register plus the per-frame valid flag. Dropping the link
   // abandons any partial frame; it is never resumed.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         tx_phy       <= '0;
         tx_frame_vld <= 1'b0;
         frame_act    <= 1'b0;
      end else if (!tx_online) begin
         tx_phy       <= '0;
         tx_frame_vld <= 1'b0;
         frame_act    <= 1'b0;
      end else begin
         tx_phy       <= phy_nxt;
         tx_frame_vld <= vld_now;
         if (beat_first) frame_act <= accept;
      end
   end

endmodule

// File: tb/tb_lpif_txrx_asym_tx_framer.sv
// Self-checking bench for lpif_txrx_asym_tx_framer. Three instances cover
// full rate (BEATS=1, persistent strobe), half rate (BEATS=2, strobe every 4)
// and quarter rate (BEATS=4, strobe every 3, moved user-bit locations).
// A frame-level reference model predicts every output each clock.
module tb_lpif_txrx_asym_tx_framer;

   localparam int NI   = 3;
   localparam int NCH  = 2;
   localparam int CHW  = 40;
   localparam int PLW  = 38;

   logic clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   logic         rst_wr_n;
   logic         online [NI];
   logic         valid  [NI];
   logic [303:0] data   [NI];
   logic         ready  [NI];
   logic         fv     [NI];
   logic [79:0]  phy    [NI];

   int checks = 0;
   int errors = 0;

   // Reference model state: online clocks since link-up, current frame word.
   int           m_cyc [NI];
   logic         m_v   [NI];
   logic [303:0] m_w   [NI];
   logic [79:0]  e_phy [NI];
   logic         e_fv  [NI];

   lpif_txrx_asym_tx_framer #(
      .NUM_CH(2), .CH_W(40), .BEATS(1), .STB_LOC(1), .MRK_LOC(39), .STB_PERIOD(0)
   ) u_dut_a (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(online[0]),
      .tx_data(data[0][75:0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
      .tx_frame_vld(fv[0]), .tx_phy(phy[0])
   );

   lpif_txrx_asym_tx_framer #(
      .NUM_CH(2), .CH_W(40), .BEATS(2), .STB_LOC(1), .MRK_LOC(39), .STB_PERIOD(4)
   ) u_dut_b (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(online[1]),
      .tx_data(data[1][151:0]), .tx_valid(valid[1]), .tx_ready(ready[1]),
      .tx_frame_vld(fv[1]), .tx_phy(phy[1])
   );

   lpif_txrx_asym_tx_framer #(
      .NUM_CH(2), .CH_W(40), .BEATS(4), .STB_LOC(5), .MRK_LOC(20), .STB_PERIOD(3)
   ) u_dut_c (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(online[2]),
      .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
      .tx_frame_vld(fv[2]), .tx_phy(phy[2])
   );

   function automatic int beats_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 4;
   endfunction
   function automatic int per_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 4 : 3;
   endfunction
   function automatic int stb_of(input int k);
      return (k == 2) ? 5 : 1;
   endfunction
   function automatic int mrk_of(input int k);
      return (k == 2) ? 20 : 39;
   endfunction

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected PHY bus for beat b of word w: walk each channel's bits in
   // ascending order, user bits at their locations, payload everywhere else.
   function automatic logic [79:0] build(input int k, input logic [303:0] w,
                                         input int b, input logic stb, input logic mrk);
      logic [79:0] r;
      int p;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         p = 0;
         for (int bit_i = 0; bit_i < CHW; bit_i++) begin
            if (bit_i == stb_of(k))      r[c*CHW + bit_i] = stb;
            else if (bit_i == mrk_of(k)) r[c*CHW + bit_i] = mrk;
            else begin
               r[c*CHW + bit_i] = w[(b*NCH + c)*PLW + p];
               p++;
            end
         end
      end
      return r;
   endfunction

   function automatic logic m_ready(input int k);
      return rst_wr_n && online[k] && (m_cyc[k] % beats_of(k) == 0);
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NI; k++) begin
         m_cyc[k] = 0;
         m_v[k]   = 1'b0;
         m_w[k]   = '0;
         e_phy[k] = '0;
         e_fv[k]  = 1'b0;
      end
   endtask

   // Advance the model by one clock edge using the current inputs.
   task automatic m_edge(input int k);
      int   b;
      logic stb;
      if (!online[k]) begin
         m_cyc[k] = 0;
         m_v[k]   = 1'b0;
         m_w[k]   = '0;
         e_phy[k] = '0;
         e_fv[k]  = 1'b0;
      end else begin
         b = m_cyc[k] % beats_of(k);
         if (b == 0) begin
            m_v[k] = valid[k];
            m_w[k] = valid[k] ? data[k] : '0;
         end
         stb      = (per_of(k) == 0) || (m_cyc[k] % per_of(k) == 0);
         e_phy[k] = build(k, m_w[k], b, stb, b == beats_of(k) - 1);
         e_fv[k]  = m_v[k];
         m_cyc[k]++;
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("phy%0d", k), phy[k], e_phy[k]);
         check($sformatf("frame_vld%0d", k), 80'(fv[k]), 80'(e_fv[k]));
      end
   endtask

   // One clock: check ready mid-cycle, step the model, check registered outputs.
   task automatic step();
      @(negedge clk_wr);
      for (int k = 0; k < NI; k++)
         check($sformatf("ready%0d", k), 80'(ready[k]), 80'(m_ready(k)));
      for (int k = 0; k < NI; k++) m_edge(k);
      @(posedge clk_wr);
      #1;
      check_outputs();
   endtask

   task automatic rand_word(input int k);
      for (int w = 0; w < 9; w++) data[k][w*32 +: 32] = $urandom;
      data[k][303:288] = 16'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s_phy%0d", tag, k), phy[k], 80'h0);
         check($sformatf("%s_vld%0d", tag, k), 80'(fv[k]), 80'h0);
         check($sformatf("%s_rdy%0d", tag, k), 80'(ready[k]), 80'h0);
      end
   endtask

   initial begin
      logic reached;
      logic [79:0] exp_a;
      rst_wr_n = 1'b1;
      for (int k = 0; k < NI; k++) begin
         online[k] = 1'b0;
         valid[k]  = 1'b0;
         data[k]   = '0;
      end
      m_reset();

      // Reset state
      #2 rst_wr_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk_wr);
      #2 rst_wr_n = 1'b1;

      // Offline after reset: nothing moves
      repeat (2) step();

      // Link up; first 9 beats: directed full-rate word on A, back-to-back
      // words on B, then idle. B's strobe must fire on beats 0,4,8 only.
      for (int k = 0; k < NI; k++) online[k] = 1'b1;
      for (int n = 0; n < 9; n++) begin
         valid[0] = (n == 0);
         data[0]  = '0;
         if (n == 0) begin
            data[0][0]  = 1'b1;
            data[0][1]  = 1'b1;
            data[0][38] = 1'b1;
         end
         valid[1] = (n < 4);
         rand_word(1);
         valid[2] = 1'b0;
         step();
         if (n == 0) begin
            exp_a = 80'h8000000003_8000000007;
            check("full_rate_map", phy[0], exp_a);
         end
         check($sformatf("stb_b0_beat%0d", n), 80'(phy[1][1]),  80'(n % 4 == 0));
         check($sformatf("stb_b1_beat%0d", n), 80'(phy[1][41]), 80'(n % 4 == 0));
      end

      // Idle frames on every instance
      for (int k = 0; k < NI; k++) valid[k] = 1'b0;
      repeat (6) step();

      // Randomised traffic with occasional link drops
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NI; k++) begin
            valid[k] = ($urandom_range(0, 3) != 0);
            rand_word(k);
            if ($urandom_range(0, 29) == 0) online[k] = ~online[k];
         end
         step();
      end

      // Quarter rate: drop the link while beat 1 is in flight
      for (int k = 0; k < NI; k++) online[k] = 1'b1;
      valid[2] = 1'b1;
      rand_word(2);
      reached = 1'b0;
      for (int n = 0; n < 12 && !reached; n++) begin
         step();
         reached = (m_cyc[2] % 4 == 1) && m_v[2];
      end
      check("quarter_sync", 80'(reached), 80'h1);
      online[2] = 1'b0;
      step();
      check("drop_phy", phy[2], 80'h0);
      check("drop_ready", 80'(ready[2]), 80'h0);
      online[2] = 1'b1;
      #1 check("reonline_ready", 80'(ready[2]), 80'h1);
      rand_word(2);
      for (int n = 0; n < 4; n++) begin
         step();
         valid[2] = 1'b0;
         check($sformatf("reonline_mrk%0d", n), 80'(phy[2][20]), 80'(n == 3));
         check($sformatf("reonline_vld%0d", n), 80'(fv[2]), 80'h1);
      end

      // Asynchronous reset in the middle of traffic
      for (int k = 0; k < NI; k++) begin
         valid[k] = 1'b1;
         rand_word(k);
      end
      repeat (3) step();
      #2 rst_wr_n = 1'b0;
      #1 check_all_zero("async_reset");
      m_reset();
      rst_wr_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < NI; k++) rand_word(k);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule
